// File: rtl/pe_pkg.sv
// Shared types and fixed-point helpers for the processing-element array.
package pe_pkg;

  typedef enum logic [0:0] {
    PE_IDLE = 1'b0,
    PE_ACC  = 1'b1
  } pe_state_t;

  // Working width for rounding/accumulate arithmetic; wide enough for any
  // product plus guard bits at the supported parameter ranges.
  localparam int unsigned CALC_W = 64;

  // Clamp a signed value to the two's-complement range of `width` bits.
  function automatic logic signed [CALC_W-1:0] sat_clamp(
    input logic signed [CALC_W-1:0] value,
    input int unsigned              width
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Half-LSB constant added before the right shift: round half up.
  function automatic logic signed [CALC_W-1:0] round_const(input int unsigned frac_w);
    return 64'sd1 <<< (frac_w - 1);
  endfunction

endpackage

// File: rtl/pe_fxp_mul.sv
// Registered signed DATA_W x DATA_W multiplier, one cycle latency (DSP friendly).
module pe_fxp_mul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                       i_clk,
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_p
);

  logic signed [2*DATA_W-1:0] r_p;

  // Full-precision product register, no reset so it packs into the DSP.
  always_ff @(posedge i_clk) begin
    r_p <= (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  end

  assign o_p = r_p;

endmodule

// File: rtl/pe_mac_acc.sv
// Fixed-point MAC processing element: streams ain against a local RAM operand,
// accumulates one framed vector and emits one saturated result per vector.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned GUARD_W    = 8,
  parameter int unsigned L_RAM_SIZE = 6
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_W-1:0]     ain,
  input  logic [DATA_W-1:0]     din,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic                  we,
  input  logic                  valid,
  input  logic                  first,
  input  logic                  last,
  output logic [DATA_W-1:0]     dout,
  output logic                  dvalid,
  output logic                  busy,
  output logic                  sat,
  output logic                  err
);

  localparam int unsigned ACC_W  = DATA_W + GUARD_W;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned DEPTH  = 2 ** L_RAM_SIZE;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic signed [DATA_W-1:0] r_ram_q;
  logic signed [DATA_W-1:0] r_s0_a;
  logic                     r_s0_first, r_s0_last;
  logic                     r_s1_first, r_s1_last;
  logic [2:0]               r_vld;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_dout;
  logic                     r_dvalid, r_sat, r_err;

  pe_state_t r_state, w_state_nxt;
  logic      w_accept, w_err_evt, w_clamp;

  logic signed [CALC_W-1:0] w_scaled, w_base, w_sum, w_acc_nxt, w_out;

  // Single-port RAM, write has priority; read data is registered (S0).
  always_ff @(posedge aclk) begin
    if (we) r_mem[addr] <= din;
    r_ram_q <= r_mem[addr];
  end

  // Control FSM: decide beat acceptance and protocol errors.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_evt   = 1'b0;
    if (valid && we) begin
      w_err_evt = 1'b1;
    end else if (valid) begin
      case (r_state)
        PE_IDLE: begin
          if (first) begin
            w_accept    = 1'b1;
            w_state_nxt = last ? PE_IDLE : PE_ACC;
          end else begin
            w_err_evt = 1'b1;
          end
        end
        PE_ACC: begin
          w_accept = 1'b1;
          if (first) w_err_evt = 1'b1;
          if (last)  w_state_nxt = PE_IDLE;
        end
        default: w_state_nxt = PE_IDLE;
      endcase
    end
  end

  // Data alignment registers travelling alongside the RAM read and product.
  always_ff @(posedge aclk) begin
    r_s0_a     <= ain;
    r_s0_first <= first;
    r_s0_last  <= last;
    r_s1_first <= r_s0_first;
    r_s1_last  <= r_s0_last;
  end

  // Pipeline valid bits S0..S2.
  always_ff @(posedge aclk) begin
    if (areset) r_vld <= '0;
    else        r_vld <= {r_vld[1:0], w_accept};
  end

  pe_fxp_mul #(.DATA_W(DATA_W)) u_mul (
    .i_clk (aclk),
    .i_a   (r_s0_a),
    .i_b   (r_ram_q),
    .o_p   (w_prod)
  );

  // S2: round/scale the product, accumulate with saturation, clamp the output.
  always_comb begin
    w_scaled = (CALC_W'(w_prod) + round_const(FRAC_W)) >>> FRAC_W;
    w_base   = CALC_W'(r_acc);
    if (r_s1_first) w_base = '0;
    w_sum     = w_base + w_scaled;
    w_acc_nxt = sat_clamp(w_sum, ACC_W);
    w_out     = sat_clamp(w_acc_nxt, DATA_W);
    w_clamp   = r_vld[1] & ((w_acc_nxt != w_sum) | (r_s1_last & (w_out != w_acc_nxt)));
  end

  // Accumulator and result registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_acc    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= r_vld[1] & r_s1_last;
      if (r_vld[1]) begin
        r_acc <= w_acc_nxt[ACC_W-1:0];
        if (r_s1_last) r_dout <= w_out[DATA_W-1:0];
      end
    end
  end

  // State register and sticky flags; a fresh clamp wins over a clearing first.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= PE_IDLE;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_evt;
      r_sat   <= w_clamp | (r_sat & ~(w_accept & first));
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign busy   = (r_state == PE_ACC) | (|r_vld);
  assign sat    = r_sat;
  assign err    = r_err;

endmodule
